// File: rtl/fpu_pkg.sv
// Shared FPU constants and the sequential divider's state encoding.
// Special-value encodings here match the adder.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN_INVALID = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } div_state_t;

endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// The core drives the master side.
interface fdiv_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        dz;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf, dz
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf, dz
  );

endinterface

// File: rtl/fdiv_special_case.sv
// Combinational classifier for NaN/inf/zero operand pairs; subnormals count as zero.
// Produces the final quotient directly when no iteration is needed.
module fdiv_special_case
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        is_special,
  output logic [31:0] y,
  output logic        dz
);

  logic             s1, s2, s;
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] m1, m2;
  logic             nan1, nan2, inf1, inf2, zero1, zero2;

  assign {s1, e1, m1} = x1;
  assign {s2, e2, m2} = x2;
  assign s = s1 ^ s2;

  assign nan1  = (&e1) && (m1 != '0);
  assign nan2  = (&e2) && (m2 != '0);
  assign inf1  = (&e1) && (m1 == '0);
  assign inf2  = (&e2) && (m2 == '0);
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);

  // NaN payloads are quieted by forcing the top mantissa bit
  always_comb begin
    is_special = 1'b1;
    y          = '0;
    dz         = 1'b0;
    if (nan1) begin
      y = {s1, {EXP_W{1'b1}}, 1'b1, m1[MAN_W-2:0]};
    end else if (nan2) begin
      y = {s2, {EXP_W{1'b1}}, 1'b1, m2[MAN_W-2:0]};
    end else if ((inf1 && inf2) || (zero1 && zero2)) begin
      y = QNAN_INVALID;
    end else if (inf1) begin
      y = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf2 || zero1) begin
      y = {s, {(EXP_W+MAN_W){1'b0}}};
    end else if (zero2) begin
      y  = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      dz = 1'b1;
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle binary32 divider: restoring division, one quotient bit per cycle,
// then a single round-to-nearest-even step before the result is presented.
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fdiv_seq_if.slave  bus
);

  localparam logic [4:0]        LAST_STEP = 5'd25;
  localparam logic signed [9:0] BIAS_E    = 10'(BIAS);

  div_state_t        state, state_next;
  logic [4:0]        cnt;
  logic [25:0]       q;
  logic [24:0]       r;
  logic [23:0]       mb;
  logic signed [9:0] exp_q;
  logic              sign;
  logic [31:0]       y_r;
  logic              ovf_r, dz_r;

  logic              sp_is_special;
  logic [31:0]       sp_y;
  logic              sp_dz;
  logic              accept;

  fdiv_special_case u_special (
    .x1         (bus.x1),
    .x2         (bus.x2),
    .is_special (sp_is_special),
    .y          (sp_y),
    .dz         (sp_dz)
  );

  assign accept = bus.in_valid && (state == IDLE);

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_next = sp_is_special ? DONE : DIV;
      end
      DIV:   if (cnt == LAST_STEP) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic        r_ge;
  logic [24:0] r_sub;

  assign r_ge  = (r >= {1'b0, mb});
  assign r_sub = r_ge ? (r - {1'b0, mb}) : r;

  logic [22:0]       frac_pre, frac;
  logic              guard, sticky, round_up, carry;
  logic signed [9:0] exp_adj, exp_fin;
  logic [31:0]       y_norm;
  logic              ovf_norm;

  // q[25] set means the quotient landed in [1,2); otherwise renormalise by one
  always_comb begin
    if (q[25]) begin
      frac_pre = q[24:2];
      guard    = q[1];
      sticky   = q[0] | (r != '0);
      exp_adj  = exp_q;
    end else begin
      frac_pre = q[23:1];
      guard    = q[0];
      sticky   = (r != '0);
      exp_adj  = exp_q - 10'sd1;
    end
    round_up      = guard & (sticky | frac_pre[0]);
    {carry, frac} = {1'b0, frac_pre} + {23'd0, round_up};
    exp_fin       = carry ? (exp_adj + 10'sd1) : exp_adj;
    ovf_norm      = 1'b0;
    if (exp_fin >= 10'sd255) begin
      y_norm   = {sign, 8'hFF, 23'd0};
      ovf_norm = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      y_norm = {sign, 31'd0};
    end else begin
      y_norm = {sign, exp_fin[7:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      mb    <= '0;
      exp_q <= '0;
      sign  <= 1'b0;
      y_r   <= '0;
      ovf_r <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          sign  <= bus.x1[31] ^ bus.x2[31];
          exp_q <= $signed({2'b00, bus.x1[30:23]}) - $signed({2'b00, bus.x2[30:23]}) + BIAS_E;
          r     <= {2'b01, bus.x1[22:0]};
          mb    <= {1'b1, bus.x2[22:0]};
          q     <= '0;
          cnt   <= '0;
          if (sp_is_special) begin
            y_r   <= sp_y;
            ovf_r <= 1'b0;
            dz_r  <= sp_dz;
          end
        end
        DIV: begin
          q   <= {q[24:0], r_ge};
          r   <= r_sub << 1;
          cnt <= (cnt == LAST_STEP) ? 5'd0 : cnt + 5'd1;
        end
        ROUND: begin
          y_r   <= y_norm;
          ovf_r <= ovf_norm;
          dz_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.y   = y_r;
  assign bus.ovf = ovf_r;
  assign bus.dz  = dz_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: vector table through a scoreboard, plus
// backpressure, busy-ignore and mid-operation reset sequences.
module tb_fdiv_seq;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;

  localparam int NL       = 28;
  localparam int SL       = 1;
  localparam int MAX_WAIT = 60;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  fdiv_seq_if bus();

  fdiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Waits for in_ready, presents one operation for a single cycle and records the expectation
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x1       = a;
    bus.x2       = b;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_output(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard actual=empty required=entry", tag);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s_out_valid", tag), 32'(bus.out_valid), 32'd1);
    check($sformatf("%s_latency", tag), 32'(lat), 32'(e.lat));
    check($sformatf("%s_y", tag), bus.y, e.y);
    check($sformatf("%s_ovf", tag), 32'(bus.ovf), 32'(e.ovf));
    check($sformatf("%s_dz", tag), 32'(bus.dz), 32'(e.dz));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("%s_released", tag), 32'(bus.out_valid), 32'd0);
    check($sformatf("%s_back_idle", tag), 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    exp_t e;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_y", bus.y, 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    check("reset_dz", 32'(bus.dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h3F800000, 32'h40A00000, 32'h3E4CCCCD, 1'b0, 1'b0, NL});
    vecs.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0, NL});
    vecs.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0, NL});
    vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'hFF7FFFFF, 32'h3F000000, 32'hFF800000, 1'b1, 1'b0, NL});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, NL});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, SL});
    vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1, SL});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'hFFC12345, 32'h3F800000, 32'hFFC12345, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h3F800000, 32'h7F800001, 32'h7FC00001, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h7FC00001, 32'hFFC00002, 32'h7FC00001, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, SL});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, SL});

    foreach (vecs[i]) begin
      e = '{vecs[i].y, vecs[i].ovf, vecs[i].dz, vecs[i].lat};
      apply_stimulus(vecs[i].x1, vecs[i].x2, e);
      wait_result(lat);
      check_output($sformatf("vec%0d", i), lat);
    end

    // New operands offered while busy must not disturb the running division
    e = '{32'h40400000, 1'b0, 1'b0, NL};
    apply_stimulus(32'h40C00000, 32'h40000000, e);
    bus.in_valid = 1'b1;
    bus.x1       = 32'h3F800000;
    bus.x2       = 32'h00000000;
    wait_result(lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_y", c), bus.y, 32'h40400000);
      check($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    lat = lat + 0;
    check_output("stall", lat);

    // Abort a division part-way through; the reset is seen without a clock edge
    e = '{32'h7F800000, 1'b1, 1'b0, NL};
    apply_stimulus(32'h7F7FFFFF, 32'h3F000000, e);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_y", bus.y, 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    e = '{32'h3EAAAAAB, 1'b0, 1'b0, NL};
    apply_stimulus(32'h3F800000, 32'h40400000, e);
    wait_result(lat);
    check_output("after_abort", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
